// File: rtl/seq_det_scheduler.sv
// ---------------------------------------------------------------------------
// seq_det_scheduler
//
// Round-robin scheduler in front of one shared serial pattern detector.
// Up to NREQ requesters raise req; one winner is granted a frame of
// FRAME_LEN bits.
//
// During the frame, the winner's bit_in lane is shifted into a history
// register, and every PAT_W-bit window equal to the programmed pattern
// counts as a match. After the last bit, one REPORT cycle pulses done with
// the winner's id and the final match count.
//
// Handshake: req is a level that is only looked at in IDLE. The frame
// starts on the clock edge where req is seen; gnt then stays high for
// exactly FRAME_LEN cycles. Dropping req after that edge has no effect.
// Configuration (cfg_we) is only accepted in IDLE.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cfg_we              pattern/mode write strobe (IDLE only)
//   cfg_pattern         new pattern; MSB is compared with the oldest bit
//   cfg_overlap         1 = overlapping matches, 0 = restart after a match
//   req[NREQ]           per-requester frame request
//   bit_in[NREQ]        per-requester serial data
//   gnt[NREQ]           one-hot grant, high for the whole SCAN state
//   busy                high in SCAN and REPORT
//   hit                 one-cycle match pulse, one cycle after the bit
//   done                one-cycle frame-complete pulse (REPORT)
//   done_id             requester of the current/last frame
//   match_cnt           matches in the current/last frame, saturates at 31
//   dbg_state           FSM state (0 IDLE, 1 SCAN, 2 REPORT)
// ---------------------------------------------------------------------------
module seq_det_scheduler #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16,
    parameter int PAT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  bit_in,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic [1:0]       done_id,
    output logic [4:0]       match_cnt,
    output logic [1:0]       dbg_state
);

    localparam int IDW = 2;
    localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int VCW = $clog2(PAT_W + 1);

    localparam logic [BCW-1:0]   LAST_BIT = BCW'(FRAME_LEN - 1);
    localparam logic [VCW-1:0]   FULL     = VCW'(PAT_W);
    localparam logic [PAT_W-1:0] RST_PAT  = PAT_W'(4'b1010);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_start;

    logic [IDW-1:0]   r_winner;
    logic [IDW-1:0]   r_last;
    logic [BCW-1:0]   r_bit_cnt;
    logic [PAT_W-1:0] r_hist;
    logic [VCW-1:0]   r_valid;
    logic [PAT_W-1:0] r_pattern;
    logic             r_overlap;
    logic             r_hit;
    logic [4:0]       r_match_cnt;

    logic [IDW-1:0]   w_pick;
    logic             w_found;
    logic [PAT_W-1:0] w_hist_next;
    logic [VCW-1:0]   w_valid_next;
    logic             w_match;

    // Round-robin search starting just above the previous winner. NREQ is a
    // power of two here, so the wrap-around is plain modular addition.
    always_comb begin
        logic [IDW-1:0] v_idx;
        w_pick  = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            v_idx = r_last + IDW'(i);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // The valid count saturates at PAT_W: only "at least PAT_W bits seen"
    // matters for the match decision.
    assign w_hist_next  = {r_hist[PAT_W-2:0], bit_in[r_winner]};
    assign w_valid_next = (r_valid == FULL) ? r_valid : r_valid + 1'b1;
    assign w_match      = (w_valid_next == FULL) && (w_hist_next == r_pattern);

    // Next-state and state-decoded outputs
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        gnt     = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next  = ST_SCAN;
                    w_start = 1'b1;
                end
            end
            ST_SCAN: begin
                gnt[r_winner] = 1'b1;
                busy          = 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner    <= '0;
            r_last      <= IDW'(NREQ - 1);  // requester 0 searched first
            r_bit_cnt   <= '0;
            r_hist      <= '0;
            r_valid     <= '0;
            r_pattern   <= RST_PAT;
            r_overlap   <= 1'b1;
            r_hit       <= 1'b0;
            r_match_cnt <= '0;
        end else begin
            r_hit <= 1'b0;
            // A write coinciding with the frame start lands on the same
            // edge, so the new frame already sees the new configuration.
            if (r_state == ST_IDLE && cfg_we) begin
                r_pattern <= cfg_pattern;
                r_overlap <= cfg_overlap;
            end
            if (w_start) begin
                r_winner    <= w_pick;
                r_last      <= w_pick;
                r_bit_cnt   <= '0;
                r_hist      <= '0;
                r_valid     <= '0;
                r_match_cnt <= '0;
            end else if (r_state == ST_SCAN) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_hist    <= w_hist_next;
                if (w_match) begin
                    r_hit <= 1'b1;
                    if (r_match_cnt != 5'd31) begin
                        r_match_cnt <= r_match_cnt + 5'd1;
                    end
                    // Non-overlapping mode needs PAT_W fresh bits.
                    r_valid <= r_overlap ? w_valid_next : '0;
                end else begin
                    r_valid <= w_valid_next;
                end
            end
        end
    end

    assign hit       = r_hit;
    assign done_id   = r_winner;
    assign match_cnt = r_match_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_det_scheduler
//
// Bench for seq_det_scheduler.
//
// A frame-level model tracks the frame phase, the winner and the list of
// bits seen in the frame. It decides matches by comparing the last PAT_W
// bits of that list with the pattern. Non-overlapping mode requires PAT_W
// bits since the previous match.
//
// A compare process checks every output at each falling edge. Directed
// frames additionally check literal hit/grant/done counts.
// ---------------------------------------------------------------------------
module tb_seq_det_scheduler;

    localparam int FRAME_LEN = 16;

    // clock / reset / stimulus signals
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       cfg_overlap = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] bit_in = 4'b0000;

    logic [3:0] gnt;
    logic       busy;
    logic       hit;
    logic       done;
    logic [1:0] done_id;
    logic [4:0] match_cnt;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    seq_det_scheduler #(.NREQ(4), .FRAME_LEN(FRAME_LEN), .PAT_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .req(req), .bit_in(bit_in), .gnt(gnt),
        .busy(busy), .hit(hit), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .dbg_state(dbg_state)
    );

    // scoreboard counters
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = idle, 1..FRAME_LEN = scan bit number, FRAME_LEN+1 = report
    int         m_phase = 0;
    int         m_win = 0;
    int         m_last = 3;
    int         m_id = 0;
    int         m_cnt = 0;
    int         m_last_match = -100;
    int         m_n = 0;
    bit         m_hit = 1'b0;
    logic [3:0] m_pat = 4'b1010;
    bit         m_ov = 1'b1;
    logic [3:0] m_w;
    bit         m_bits[$];

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_hit = 1'b0; m_cnt = 0; m_id = 0; m_win = 0;
            m_last = 3; m_pat = 4'b1010; m_ov = 1'b1;
        end else begin
            m_hit = 1'b0;
            if (m_phase == 0) begin
                if (cfg_we) begin
                    m_pat = cfg_pattern;
                    m_ov  = cfg_overlap;
                end
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (req[2'((m_last + k) % 4)]) begin
                            m_win = (m_last + k) % 4;
                            break;
                        end
                    end
                    m_last = m_win;
                    m_id = m_win;
                    m_bits.delete();
                    m_cnt = 0;
                    m_last_match = -100;
                    m_phase = 1;
                end
            end else if (m_phase <= FRAME_LEN) begin
                m_bits.push_back(bit_in[2'(m_win)]);
                m_n = m_bits.size();
                if (m_n >= 4) begin
                    m_w = {m_bits[m_n-4], m_bits[m_n-3], m_bits[m_n-2], m_bits[m_n-1]};
                    if (m_w == m_pat && (m_ov || (m_n - m_last_match) >= 4)) begin
                        m_hit = 1'b1;
                        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
                        m_last_match = m_n;
                    end
                end
                m_phase++;
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- compare process + observation ----------------
    bit         chk_en = 1'b0;
    int         cyc = 0;
    logic [3:0] e_gnt;
    int         obs_gnt_cyc[4] = '{0, 0, 0, 0};
    int         obs_gnt_any = 0;
    int         obs_hits = 0;
    int         obs_dones = 0;
    int         obs_last_id = 0;
    int         obs_last_cnt = 0;
    int         obs_done_ids[$];
    int         obs_done_cyc[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            e_gnt = 4'b0000;
            if (m_phase >= 1 && m_phase <= FRAME_LEN) e_gnt[2'(m_win)] = 1'b1;
            chk("gnt", int'(gnt), int'(e_gnt));
            chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("dbg_not_idle", (dbg_state != 2'd0) ? 1 : 0, (m_phase != 0) ? 1 : 0);
            chk("hit", int'(hit), int'(m_hit));
            chk("done", int'(done), (m_phase == FRAME_LEN + 1) ? 1 : 0);
            chk("done_id", int'(done_id), m_id);
            chk("match_cnt", int'(match_cnt), m_cnt);
            for (int k = 0; k < 4; k++) begin
                if (gnt == (4'b0001 << k)) obs_gnt_cyc[k]++;
            end
            if (gnt != 4'b0000) obs_gnt_any++;
            if (hit) obs_hits++;
            if (done) begin
                obs_dones++;
                obs_last_id = int'(done_id);
                obs_last_cnt = int'(match_cnt);
                obs_done_ids.push_back(int'(done_id));
                obs_done_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    int s_gnt[4];
    int s_any, s_hits, s_dones;

    task automatic begin_obs();
        for (int k = 0; k < 4; k++) s_gnt[k] = obs_gnt_cyc[k];
        s_any = obs_gnt_any;
        s_hits = obs_hits;
        s_dones = obs_dones;
    endtask

    task automatic end_obs(input string tag, input int lane, input int hits, input int cnt);
        chk({tag, "_gnt_lane"}, obs_gnt_cyc[lane] - s_gnt[lane], FRAME_LEN);
        chk({tag, "_gnt_any"}, obs_gnt_any - s_any, FRAME_LEN);
        chk({tag, "_hits"}, obs_hits - s_hits, hits);
        chk({tag, "_dones"}, obs_dones - s_dones, 1);
        chk({tag, "_done_id"}, obs_last_id, lane);
        chk({tag, "_final_cnt"}, obs_last_cnt, cnt);
    endtask

    // One frame from IDLE: req raised for one IDLE cycle (or until bit
    // drop_at), stream MSB first on every lane. cfg_mode 1 writes config in
    // the start cycle, cfg_mode 2 writes it during scan bit 4.
    task automatic run_frame(input logic [3:0] rq, input logic [15:0] stream,
                             input int drop_at, input int cfg_mode,
                             input logic [3:0] pat, input logic ov);
        @(negedge clk);
        req = rq;
        if (cfg_mode == 1) begin
            cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ov;
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            bit_in = {4{stream[4'(15 - i)]}};
            if (i == 0) cfg_we = 1'b0;
            if (i == drop_at) req = 4'b0000;
            if (cfg_mode == 2 && i == 3) begin
                cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ov;
            end
            if (cfg_mode == 2 && i == 4) cfg_we = 1'b0;
        end
        @(negedge clk);   // report cycle
        @(negedge clk);   // idle cycle
    endtask

    task automatic cfg_write(input logic [3:0] pat, input logic ov);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ov;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    int b;
    int exp_ids[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // default pattern 1010, overlapping
        begin_obs(); run_frame(4'b0001, 16'hAAAA, 0, 0, 4'b0000, 1'b0);
        end_obs("ovl_1010", 0, 7, 7);

        cfg_write(4'b1010, 1'b0);
        begin_obs(); run_frame(4'b0001, 16'hAAAA, 0, 0, 4'b0000, 1'b0);
        end_obs("novl_1010", 0, 4, 4);

        cfg_write(4'b1111, 1'b1);
        begin_obs(); run_frame(4'b0001, 16'hFFFF, 0, 0, 4'b0000, 1'b0);
        end_obs("ovl_1111", 0, 13, 13);

        cfg_write(4'b1111, 1'b0);
        begin_obs(); run_frame(4'b0001, 16'hFFFF, 0, 0, 4'b0000, 1'b0);
        end_obs("novl_1111", 0, 4, 4);

        // config write coinciding with the request is used by that frame
        begin_obs(); run_frame(4'b0001, 16'hAAAA, 0, 1, 4'b1010, 1'b1);
        end_obs("cfg_at_start", 0, 7, 7);

        // config write during scan ignored, this frame and the next
        begin_obs(); run_frame(4'b0001, 16'hAAAA, 0, 2, 4'b1111, 1'b0);
        end_obs("cfg_in_scan", 0, 7, 7);
        begin_obs(); run_frame(4'b0001, 16'hAAAA, 0, 0, 4'b0000, 1'b0);
        end_obs("cfg_kept", 0, 7, 7);

        // req dropped at scan bit 5 still gives a full frame
        begin_obs(); run_frame(4'b0010, 16'hAAAA, 5, 0, 4'b0000, 1'b0);
        end_obs("req_drop", 1, 7, 7);

        // reset in the middle of a frame
        begin_obs();
        @(negedge clk);
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bit_in = 4'($urandom);
            if (i == 0) req = 4'b0000;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_match_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", obs_dones - s_dones, 0);

        // all requesters held: round-robin from 0, 18 cycles per frame
        b = obs_done_ids.size();
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bit_in = 4'($urandom);
            if (i == 80) req = 4'b0000;
        end
        chk("rr_done_count", obs_done_ids.size() - b, 5);
        if (obs_done_ids.size() - b >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_done_id", obs_done_ids[b + i], exp_ids[i]);
            for (int i = 1; i < 5; i++) chk("rr_spacing", obs_done_cyc[b + i] - obs_done_cyc[b + i - 1], 18);
        end

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bit_in = 4'($urandom);
            req = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cfg_we = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: cfg_pattern = 4'b1010;
                1: cfg_pattern = 4'b1111;
                2: cfg_pattern = 4'b0110;
                default: cfg_pattern = 4'($urandom);
            endcase
            cfg_overlap = 1'($urandom_range(0, 1));
        end
        req = 4'b0000;
        cfg_we = 1'b0;
        repeat (25) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
